rob_core: RTL and testbench

ROB_CORE -- requirements
Module: rob_core

---
 rtl/rob_core.sv | 81 ++++++++
 tb/tb_rob_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_core.sv
// rob_core: 32-entry in-order-retire reorder buffer with three writeback ports and branch flush.
module rob_core #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_valid,
  input  logic [6:0]  alloc_pd_new,
  input  logic [6:0]  alloc_pd_old,
  input  logic [31:0] alloc_pc,
  output logic        alloc_ready,
  output logic [4:0]  alloc_tag,
  input  logic        wb_alu_valid,
  input  logic [4:0]  wb_alu_tag,
  input  logic        wb_mem_valid,
  input  logic [4:0]  wb_mem_tag,
  input  logic        wb_br_valid,
  input  logic [4:0]  wb_br_tag,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  output logic        retire_valid,
  output logic [6:0]  retire_pd_old,
  output logic [6:0]  retire_pd_new,
  output logic [31:0] retire_pc,
  output logic        rob_empty,
  output logic        rob_full
);
  localparam logic [5:0] CAP = 6'(DEPTH);
  logic [DEPTH-1:0] valid, complete, wb_set, kill, alloc_set;
  logic [6:0]       pd_new_q [DEPTH];
  logic [6:0]       pd_old_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [4:0]       head, tail, flush_n;
  logic [5:0]       count, count_nx;
  logic             do_alloc, retire, flush;
  assign alloc_ready   = count < CAP && !mispredict;
  assign alloc_tag     = tail;
  assign do_alloc      = alloc_valid && alloc_ready;
  assign retire        = valid[head] && complete[head];
  assign flush         = mispredict && valid[mispredict_tag];
  assign flush_n       = tail - mispredict_tag - 5'd1;
  assign retire_valid  = retire;
  assign retire_pd_old = pd_old_q[head];
  assign retire_pd_new = pd_new_q[head];
  assign retire_pc     = pc_q[head];
  assign rob_empty     = count == 6'd0;
  assign rob_full      = count == CAP;
  // Branch at head-1 of a full buffer must keep count at 32, hence the 6-bit sum.
  assign count_nx = (flush ? {1'b0, mispredict_tag - head} + 6'd1 : count + {5'd0, do_alloc}) - {5'd0, retire};
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [4:0] off;
    assign off          = 5'(i) - mispredict_tag - 5'd1;
    assign wb_set[i]    = valid[i] && ((wb_alu_valid && wb_alu_tag == 5'(i)) ||
                                       (wb_mem_valid && wb_mem_tag == 5'(i)) ||
                                       (wb_br_valid && wb_br_tag == 5'(i)));
    assign kill[i]      = (flush && off < flush_n) || (retire && head == 5'(i));
    assign alloc_set[i] = do_alloc && tail == 5'(i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      valid    <= (valid & ~kill) | alloc_set;
      complete <= (complete | wb_set) & ~kill & ~alloc_set;
      count    <= count_nx;
      head     <= head + 5'(retire);
      tail     <= flush ? mispredict_tag + 5'd1 : tail + 5'(do_alloc);
    end
  end
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      pd_new_q[tail] <= alloc_pd_new;
      pd_old_q[tail] <= alloc_pd_old;
      pc_q[tail]     <= alloc_pc;
    end
  end
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed scenarios plus randomized traffic against a program-order queue model.
module tb_rob_core;
  logic clk = 1'b0;
  logic reset, alloc_valid, alloc_ready, wb_alu_valid, wb_mem_valid, wb_br_valid, mispredict;
  logic retire_valid, rob_empty, rob_full;
  logic [6:0] alloc_pd_new, alloc_pd_old, retire_pd_old, retire_pd_new;
  logic [31:0] alloc_pc, retire_pc;
  logic [4:0] alloc_tag, wb_alu_tag, wb_mem_tag, wb_br_tag, mispredict_tag;
  int n_chk = 0, n_fail = 0;

  rob_core #(.DEPTH(32)) dut (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new),
    .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_alu_valid(wb_alu_valid), .wb_alu_tag(wb_alu_tag), .wb_mem_valid(wb_mem_valid), .wb_mem_tag(wb_mem_tag),
    .wb_br_valid(wb_br_valid), .wb_br_tag(wb_br_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .retire_valid(retire_valid), .retire_pd_old(retire_pd_old), .retire_pd_new(retire_pd_new),
    .retire_pc(retire_pc), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  // Model: live instructions oldest-first, plus the tag the next allocation will receive.
  typedef struct {
    logic [4:0]  tag;
    logic [6:0]  pdn;
    logic [6:0]  pdo;
    logic [31:0] pc;
    bit          done;
  } ent_t;
  ent_t q[$];
  logic [4:0] nt = '0;

  task automatic tick();
    bit ret, alc;
    int k;
    @(posedge clk);
    if (reset) begin
      q.delete();
      nt = '0;
    end else begin
      ret = q.size() > 0 && q[0].done;
      alc = alloc_valid && q.size() < 32 && !mispredict;
      foreach (q[j])
        if ((wb_alu_valid && wb_alu_tag == q[j].tag) || (wb_mem_valid && wb_mem_tag == q[j].tag) ||
            (wb_br_valid && wb_br_tag == q[j].tag)) q[j].done = 1'b1;
      k = -1;
      if (mispredict) foreach (q[j]) if (q[j].tag == mispredict_tag) k = j;
      if (k >= 0) begin
        while (q.size() > k + 1) void'(q.pop_back());
        nt = mispredict_tag + 5'd1;
      end
      if (ret) void'(q.pop_front());
      if (alc) begin
        q.push_back('{nt, alloc_pd_new, alloc_pd_old, alloc_pc, 1'b0});
        nt = nt + 5'd1;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; alloc_valid = 0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_pc = '0;
    wb_alu_valid = 0; wb_mem_valid = 0; wb_br_valid = 0;
    wb_alu_tag = '0; wb_mem_tag = '0; wb_br_tag = '0; mispredict = 0; mispredict_tag = '0;
  endtask

  task automatic alloc_in(input logic [31:0] pc);
    alloc_valid = 1; alloc_pc = pc; alloc_pd_new = 7'(pc >> 2); alloc_pd_old = 7'(pc >> 2) + 7'd1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_chk++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", alloc_ready); end
    n_chk++; if (alloc_tag !== 5'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", alloc_tag); end
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", retire_valid); end
    n_chk++; if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", rob_empty, rob_full); end
  endtask

  task automatic test_inorder();
    do_reset();
    for (int i = 0; i < 3; i++) begin alloc_in(32'(i * 4)); tick(); end
    idle(); wb_alu_valid = 1; wb_alu_tag = 5'd2; #1;
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early got %b want 0", retire_valid); end
    tick(); wb_alu_tag = 5'd0; #1;
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_bypass got %b want 0", retire_valid); end
    tick(); wb_alu_tag = 5'd1; #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h0 || retire_pd_old !== 7'd1) begin n_fail++; $display("FAIL ooo_r0 got rv=%b pc=%h pdo=%0d want 1 0 1", retire_valid, retire_pc, retire_pd_old); end
    tick(); idle(); #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h4 || retire_pd_new !== 7'd1) begin n_fail++; $display("FAIL ooo_r1 got rv=%b pc=%h pdn=%0d want 1 4 1", retire_valid, retire_pc, retire_pd_new); end
    tick(); #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h8) begin n_fail++; $display("FAIL ooo_r2 got rv=%b pc=%h want 1 8", retire_valid, retire_pc); end
    tick(); #1;
    n_chk++; if (retire_valid !== 1'b0 || rob_empty !== 1'b1) begin n_fail++; $display("FAIL ooo_done got rv=%b e=%b want 0 1", retire_valid, rob_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin alloc_in(32'h100 + 32'(i * 4)); tick(); end
    #1;
    n_chk++; if (rob_full !== 1'b1 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got f=%b r=%b want 1 0", rob_full, alloc_ready); end
    tick(); #1;
    n_chk++; if (rob_full !== 1'b1 || alloc_tag !== 5'd0) begin n_fail++; $display("FAIL full_reject got f=%b tag=%0d want 1 0", rob_full, alloc_tag); end
    wb_alu_valid = 1; wb_alu_tag = 5'd0; alloc_in(32'h900); tick(); wb_alu_valid = 0; #1;
    n_chk++; if (retire_valid !== 1'b1 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_retire got rv=%b r=%b want 1 0", retire_valid, alloc_ready); end
    tick(); #1;
    n_chk++; if (rob_full !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 5'd0) begin n_fail++; $display("FAIL full_wrap got f=%b r=%b tag=%0d want 0 1 0", rob_full, alloc_ready, alloc_tag); end
    tick(); idle(); #1;
    n_chk++; if (rob_full !== 1'b1 || alloc_tag !== 5'd1) begin n_fail++; $display("FAIL full_again got f=%b tag=%0d want 1 1", rob_full, alloc_tag); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 10; i++) begin alloc_in(32'(i * 4)); tick(); end
    idle(); mispredict = 1; mispredict_tag = 5'd4; alloc_valid = 1; #1;
    n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL mp_ready got %b want 0", alloc_ready); end
    tick(); idle(); #1;
    n_chk++; if (alloc_tag !== 5'd5) begin n_fail++; $display("FAIL mp_tag got %0d want 5", alloc_tag); end
    wb_alu_valid = 1; wb_alu_tag = 5'd7; wb_mem_valid = 1; wb_mem_tag = 5'd0; wb_br_valid = 1; wb_br_tag = 5'd1; tick();
    wb_alu_tag = 5'd2; wb_mem_tag = 5'd3; wb_br_tag = 5'd4; #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h0) begin n_fail++; $display("FAIL mp_r0 got rv=%b pc=%h want 1 0", retire_valid, retire_pc); end
    tick(); idle();
    for (int i = 1; i < 5; i++) begin
      #1;
      n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL mp_r%0d got rv=%b pc=%h want 1 %h", i, retire_valid, retire_pc, i * 4); end
      tick();
    end
    #1;
    n_chk++; if (retire_valid !== 1'b0 || rob_empty !== 1'b1) begin n_fail++; $display("FAIL mp_end got rv=%b e=%b want 0 1", retire_valid, rob_empty); end
  endtask

  task automatic test_wrap_flush();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      alloc_in(32'(i)); tick(); idle();
      wb_alu_valid = 1; wb_alu_tag = 5'(i); tick(); idle(); tick();
    end
    #1;
    n_chk++; if (alloc_tag !== 5'd30 || rob_empty !== 1'b1) begin n_fail++; $display("FAIL wf_pre got tag=%0d e=%b want 30 1", alloc_tag, rob_empty); end
    for (int i = 0; i < 6; i++) begin alloc_in(32'h1000 + 32'(i * 4)); tick(); end
    idle(); wb_alu_valid = 1; wb_alu_tag = 5'd30; tick(); idle();
    mispredict = 1; mispredict_tag = 5'd31; #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h1000) begin n_fail++; $display("FAIL wf_ret got rv=%b pc=%h want 1 1000", retire_valid, retire_pc); end
    tick(); idle(); #1;
    n_chk++; if (alloc_tag !== 5'd0 || rob_empty !== 1'b0 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL wf_post got tag=%0d e=%b rv=%b want 0 0 0", alloc_tag, rob_empty, retire_valid); end
    wb_alu_valid = 1; wb_alu_tag = 5'd31; tick(); idle(); #1;
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 32'h1004) begin n_fail++; $display("FAIL wf_br got rv=%b pc=%h want 1 1004", retire_valid, retire_pc); end
    tick(); #1;
    n_chk++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL wf_count got e=%b want 1", rob_empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin alloc_in(32'(i * 4)); tick(); end
    idle(); wb_alu_valid = 1; wb_alu_tag = 5'd5; wb_mem_valid = 1; wb_mem_tag = 5'd6; tick();
    wb_alu_tag = 5'd7; wb_mem_tag = 5'd8; tick(); idle();
    reset = 1; alloc_in(32'h40); tick(); idle(); #1;
    n_chk++; if (rob_empty !== 1'b1 || retire_valid !== 1'b0 || alloc_tag !== 5'd0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rmid got e=%b rv=%b tag=%0d r=%b want 1 0 0 1", rob_empty, retire_valid, alloc_tag, alloc_ready); end
  endtask

  task automatic test_random();
    bit hi, e_rv;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      hi = ((c / 300) % 2) == 1;
      idle();
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 7) < (hi ? 7 : 4)) alloc_in($urandom);
      alloc_pd_new = 7'($urandom); alloc_pd_old = 7'($urandom);
      wb_alu_valid = $urandom_range(0, 7) < (hi ? 2 : 6);
      wb_mem_valid = $urandom_range(0, 7) < (hi ? 2 : 5);
      wb_br_valid  = $urandom_range(0, 7) < (hi ? 1 : 4);
      wb_alu_tag = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : 5'($urandom);
      wb_mem_tag = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : 5'($urandom);
      wb_br_tag  = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag : 5'($urandom);
      mispredict = $urandom_range(0, 15) == 0;
      mispredict_tag = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : 5'($urandom);
      #1;
      e_rv = q.size() > 0 && q[0].done;
      n_chk++; if (alloc_ready !== (q.size() < 32 && !mispredict)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, alloc_ready, q.size() < 32 && !mispredict); end
      n_chk++; if (alloc_tag !== nt) begin n_fail++; $display("FAIL rnd_tag c=%0d got %0d want %0d", c, alloc_tag, nt); end
      n_chk++; if (retire_valid !== e_rv) begin n_fail++; $display("FAIL rnd_rv c=%0d got %b want %b", c, retire_valid, e_rv); end
      n_chk++; if (rob_empty !== (q.size() == 0) || rob_full !== (q.size() == 32)) begin n_fail++; $display("FAIL rnd_flags c=%0d got e=%b f=%b want size %0d", c, rob_empty, rob_full, q.size()); end
      if (e_rv) begin
        n_chk++; if (retire_pc !== q[0].pc || retire_pd_new !== q[0].pdn || retire_pd_old !== q[0].pdo) begin n_fail++; $display("FAIL rnd_payload c=%0d got %h/%0d/%0d want %h/%0d/%0d", c, retire_pc, retire_pd_new, retire_pd_old, q[0].pc, q[0].pdn, q[0].pdo); end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_inorder();
    test_full();
    test_mispredict();
    test_wrap_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
